// File: rtl/gray_tracker.sv
// Tracks a 3-bit Gray counter: decodes it, checks every step is a hold or a
// single +1 Gray step, counts wraps and cross-checks the sticky overflow flag.
module gray_tracker #(
  parameter int WRAP_W = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [2:0]        Gray,
  input  logic              Overflow,
  input  logic              CntReset,
  output logic [2:0]        Bin,
  output logic [WRAP_W-1:0] Wraps,
  output logic              Locked,
  output logic              Error,
  output logic [1:0]        ErrCode
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TRACK   = 2'd1,
    RESTART = 2'd2,
    FAULT   = 2'd3
  } state_e;

  localparam logic [1:0] CODE_NONE    = 2'b00;
  localparam logic [1:0] CODE_STEP    = 2'b01;
  localparam logic [1:0] CODE_OVF     = 2'b10;
  localparam logic [1:0] CODE_RESTART = 2'b11;

  function automatic logic [2:0] gray2bin(input logic [2:0] g);
    logic [2:0] b;
    b[2] = g[2];
    b[1] = b[2] ^ g[1];
    b[0] = b[1] ^ g[0];
    return b;
  endfunction

  function automatic logic [2:0] bin2gray(input logic [2:0] b);
    return b ^ (b >> 1);
  endfunction

  state_e            state_q;
  logic [2:0]        prev_q;
  logic [2:0]        bin_q;
  logic [WRAP_W-1:0] wraps_q;
  logic              locked_q;
  logic              error_q;
  logic [1:0]        code_q;
  logic              ovf_q;

  logic [2:0]        next_gray_s;
  logic              hold_s;
  logic              step_s;
  logic              wrap_s;
  logic              ovf_bad_s;
  logic [WRAP_W-1:0] wraps_d;

  // Legality of the current sample against the reference, plus overflow consistency
  always_comb begin
    next_gray_s = bin2gray(gray2bin(prev_q) + 3'd1);
    hold_s      = (Gray == prev_q);
    step_s      = (Gray == next_gray_s);
    wrap_s      = step_s && (prev_q == 3'b100);
    if (wrap_s) begin
      ovf_bad_s = ~Overflow;
    end else begin
      ovf_bad_s = (Overflow != ovf_q);
    end
    if (&wraps_q) begin
      wraps_d = wraps_q;
    end else begin
      wraps_d = wraps_q + WRAP_W'(1);
    end
  end

  // Tracker state machine with registered status outputs
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= IDLE;
      prev_q   <= 3'b000;
      bin_q    <= 3'b000;
      wraps_q  <= '0;
      locked_q <= 1'b0;
      error_q  <= 1'b0;
      code_q   <= CODE_NONE;
      ovf_q    <= 1'b0;
    end else begin
      bin_q <= gray2bin(Gray);
      if (CntReset) begin
        state_q  <= RESTART;
        wraps_q  <= '0;
        locked_q <= 1'b0;
        error_q  <= 1'b0;
        code_q   <= CODE_NONE;
        ovf_q    <= 1'b0;
      end else begin
        ovf_q <= Overflow;
        case (state_q)
          IDLE: begin
            prev_q   <= Gray;
            state_q  <= TRACK;
            locked_q <= 1'b1;
          end
          RESTART: begin
            if (Gray == 3'b000) begin
              prev_q   <= 3'b000;
              state_q  <= TRACK;
              locked_q <= 1'b1;
            end else begin
              state_q  <= FAULT;
              locked_q <= 1'b0;
              error_q  <= 1'b1;
              code_q   <= CODE_RESTART;
            end
          end
          TRACK: begin
            // Step check outranks the overflow check when both fail together
            if (!hold_s && !step_s) begin
              state_q  <= FAULT;
              locked_q <= 1'b0;
              error_q  <= 1'b1;
              code_q   <= CODE_STEP;
            end else if (ovf_bad_s) begin
              state_q  <= FAULT;
              locked_q <= 1'b0;
              error_q  <= 1'b1;
              code_q   <= CODE_OVF;
            end else begin
              prev_q <= Gray;
              if (wrap_s) begin
                wraps_q <= wraps_d;
              end else begin
                wraps_q <= wraps_q;
              end
            end
          end
          FAULT: begin
            locked_q <= 1'b0;
            error_q  <= 1'b1;
          end
          default: begin
            state_q  <= IDLE;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign Bin     = bin_q;
  assign Wraps   = wraps_q;
  assign Locked  = locked_q;
  assign Error   = error_q;
  assign ErrCode = code_q;

endmodule

// File: doc/gray_tracker.md
Name: gray_tracker

Overview:
- Downstream consumer of the 3-bit Gray counter (Output/Overflow).
- Samples the counter's Gray output every clock, decodes it to binary, and checks that each step is legal (hold, or a single +1 Gray step).
- Counts wrap-arounds and cross-checks the counter's sticky Overflow flag.
- Provides a lock/fault status for the surrounding datapath and for bench self-checking.

Parameters:
- WRAP_W, 8, width of the saturating wrap counter Wraps.

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Gray  in  3  counter Output, same clock domain.
- Overflow  in  1  counter Overflow flag (sticky until counter reset).
- CntReset  in  1  mirror of the counter's synchronous reset.
- Bin  out  3  registered binary decode of the last sampled Gray.
- Wraps  out  WRAP_W  number of 7->0 wraps seen since last reset/CntReset; saturates at all-ones.
- Locked  out  1  tracker holds a valid reference sample and no fault.
- Error  out  1  sticky fault flag.
- ErrCode  out  2  first fault cause: 01 illegal step, 10 overflow mismatch, 11 bad restart; 00 no fault.

Behaviour:
- Reset low (async): state IDLE; Bin=0, Wraps=0, Locked=0, Error=0, ErrCode=00, prev=000.
- Decode: b2=g2, b1=g2^g1, b0=b1^g0. Bin is updated every edge in every state (1-cycle latency from Gray to Bin).
- next(prev) = Gray encoding of (bin(prev)+1) mod 8. Gray sequence: 000,001,011,010,110,111,101,100.
- Priority at each edge: Reset > CntReset > state logic.
- CntReset=1 at an edge:
  - state RESTART; Wraps=0, Error=0, ErrCode=00, Locked=0.
  - Gray at that edge is not checked.
- State IDLE: first edge after Reset release (CntReset=0) captures prev=Gray (any value accepted); state TRACK, Locked=1.
- State RESTART: next edge with CntReset=0 requires Gray=000.
  - Gray=000: prev=000, state TRACK, Locked=1.
  - Otherwise: FAULT, ErrCode=11.
- State TRACK, each edge:
  - Gray==prev: legal hold; prev unchanged.
  - Gray==next(prev): legal step; prev=Gray.
  - Any other value: FAULT, ErrCode=01.
  - Wrap = legal step from prev=100 to Gray=000.
  - On a wrap, Wraps += 1 unless already all-ones.
  - Overflow must be 1 at the wrap edge, else FAULT, ErrCode=10.
  - Overflow rising (prev Overflow sample 0, now 1) at a non-wrap edge: FAULT, ErrCode=10.
  - Overflow falling without CntReset: FAULT, ErrCode=10.
  - Illegal step and overflow mismatch at the same edge: ErrCode=01 (step check has priority).
- State FAULT:
  - Error=1, Locked=0; ErrCode and Wraps frozen; Bin keeps tracking.
  - Exits only via Reset or CntReset.
- Overflow sample register resets to 0 and is cleared by CntReset.
- Wraps saturates: no roll-over to 0.

Test Plan:
- Reset low, release, counter enabled from 000 for 7 cycles -> Bin follows 0..7 one cycle after each Gray; Locked=1; Error=0; Wraps=0.
- Continue through 100->000 with Overflow=1 at that edge -> Wraps=1, no fault. Run 40 more steps -> Wraps=6. With WRAP_W=2 and 5 wraps -> Wraps=3 (saturated).
- Force Gray 001->010 (skip) -> next edge Error=1, ErrCode=01, Locked=0; further legal steps leave ErrCode=01 and Wraps frozen while Bin still updates.
- Wrap 100->000 with Overflow held 0 -> ErrCode=10. Separately, Overflow pulses 1 at Gray 011 -> ErrCode=10.
- From FAULT, CntReset=1 for one cycle, then Gray=000 -> Error=0, ErrCode=00, Wraps=0, Locked=1 one edge after CntReset falls. Repeat with Gray=011 after CntReset -> ErrCode=11.
- Assert Reset low mid-count (Gray=110, Wraps=2) between edges -> outputs go to reset values immediately. After release, first sample 110 is accepted without fault and Locked=1.
